// File: rtl/clkgen_m.sv
// CPU phi1/phi2 generator: follows BBC phi0 in slow mode, free-runs from bbc_ck8 in
// high-speed mode, and stretches phi1 so BBC accesses land on a BBC-aligned phi2.
module clkgen_m #(
  parameter int FAULT_LIMIT = 32
) (
  input  logic bbc_ck8,
  input  logic reset,
  input  logic bbc_ck2_phi0,
  input  logic hsclk_en,
  input  logic div_en,
  input  logic div4not2,
  input  logic bbc_access_req,
  output logic cpu_ck_phi2,
  output logic cpu_ck_phi1,
  output logic bbc_cycle,
  output logic locked,
  output logic sync_fault
);
  localparam int FW = $clog2(FAULT_LIMIT + 1);
  localparam logic [FW-1:0] FAULT_MAX = FW'(FAULT_LIMIT);

  typedef enum logic [1:0] {FAST_PH1, FAST_PH2, SYNC_PH1, SYNC_PH2} state_t;

  state_t        state_q, state_d;
  logic          phi0_s_q, phi0_s_d;
  logic          phi0_d_q, phi0_d_d;
  logic          armed_q, armed_d;
  logic [1:0]    ph_q, ph_d;
  logic          locked_q, locked_d;
  logic [FW-1:0] fault_cnt_q, fault_cnt_d;
  logic          sync_fault_q, sync_fault_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          phi2_q, phi2_d;
  logic          phi1_q, phi1_d;
  logic          bbc_cycle_q, bbc_cycle_d;
  logic          rise;
  logic [1:0]    last_cnt;

  // phi0 synchroniser, phase tracker and lock-loss watchdog
  always_comb begin
    phi0_s_d = bbc_ck2_phi0;
    phi0_d_d = phi0_s_q;
    armed_d  = armed_q | ~phi0_s_q;
    rise     = armed_q & phi0_s_q & ~phi0_d_q;
    ph_d     = rise ? 2'd1 : ph_q + 2'd1;

    locked_d = locked_q;
    if (rise) begin
      locked_d = (ph_q == 2'd0);
    end else if (ph_q == 2'd0) begin
      locked_d = 1'b0;
    end

    fault_cnt_d = fault_cnt_q;
    if (locked_q) begin
      fault_cnt_d = '0;
    end else if (fault_cnt_q != FAULT_MAX) begin
      fault_cnt_d = fault_cnt_q + FW'(1);
    end
    sync_fault_d = sync_fault_q | (fault_cnt_d == FAULT_MAX);
  end

  // Phase sequencer; mode only reloads when a new phi1 begins
  always_comb begin
    last_cnt = ~mode_q[1] ? 2'd0 : (mode_q[0] ? 2'd3 : 2'd1);
    state_d  = state_q;
    mode_d   = mode_q;
    case (state_q)
      FAST_PH1: begin
        if (cnt_q == last_cnt) begin
          state_d = bbc_access_req ? SYNC_PH1 : FAST_PH2;
        end
      end
      FAST_PH2: begin
        if (cnt_q == last_cnt) begin
          state_d = hsclk_en ? FAST_PH1 : SYNC_PH1;
          mode_d  = {div_en, div4not2};
        end
      end
      SYNC_PH1: begin
        // ph==3 while locked: phi0_s rises on the coming edge
        if (locked_q && (ph_q == 2'd3)) begin
          state_d = SYNC_PH2;
        end
      end
      SYNC_PH2: begin
        if (cnt_q == 2'd1) begin
          state_d = hsclk_en ? FAST_PH1 : SYNC_PH1;
          mode_d  = {div_en, div4not2};
        end
      end
      default: state_d = SYNC_PH1;
    endcase

    cnt_d       = (state_d != state_q) ? 2'd0 : cnt_q + 2'd1;
    phi2_d      = (state_d == FAST_PH2) || (state_d == SYNC_PH2);
    phi1_d      = ~phi2_d;
    bbc_cycle_d = (state_d == SYNC_PH2);
  end

  always_ff @(posedge bbc_ck8 or posedge reset) begin
    if (reset) begin
      state_q      <= SYNC_PH1;
      phi0_s_q     <= 1'b0;
      phi0_d_q     <= 1'b0;
      armed_q      <= 1'b0;
      ph_q         <= 2'd0;
      locked_q     <= 1'b0;
      fault_cnt_q  <= '0;
      sync_fault_q <= 1'b0;
      cnt_q        <= 2'd0;
      mode_q       <= 2'd0;
      phi2_q       <= 1'b0;
      phi1_q       <= 1'b1;
      bbc_cycle_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phi0_s_q     <= phi0_s_d;
      phi0_d_q     <= phi0_d_d;
      armed_q      <= armed_d;
      ph_q         <= ph_d;
      locked_q     <= locked_d;
      fault_cnt_q  <= fault_cnt_d;
      sync_fault_q <= sync_fault_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      phi2_q       <= phi2_d;
      phi1_q       <= phi1_d;
      bbc_cycle_q  <= bbc_cycle_d;
    end
  end

  assign cpu_ck_phi2 = phi2_q;
  assign cpu_ck_phi1 = phi1_q;
  assign bbc_cycle   = bbc_cycle_q;
  assign locked      = locked_q;
  assign sync_fault  = sync_fault_q;

endmodule

// File: doc/clkgen_m.md
# clkgen_m

CPU clock generator sitting directly upstream of the bus-interface stage. It derives `cpu_ck_phi2`/`cpu_ck_phi1` from `bbc_ck8`. In slow mode it tracks the BBC 2MHz `bbc_ck2_phi0`. In high-speed mode it runs free at a divided `bbc_ck8` rate, and it stretches phi1 so that any access targeting BBC memory or IO gets a phi2 phase-aligned with BBC phi2.

## Interface
- `FAULT_LIMIT`, default 32: consecutive unlocked `bbc_ck8` cycles before `sync_fault` sets.
- `bbc_ck8`  input  1  sole clock; all flops on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `bbc_ck2_phi0`  input  1  BBC 2MHz phi0. Phase-locked to `bbc_ck8` with a period of 4 `bbc_ck8` cycles: 2 cycles high, 2 cycles low.
- `hsclk_en`  input  1  selects high-speed mode (map register bit 3).
- `div_en`  input  1  divider enable (map bit 1).
- `div4not2`  input  1  divide by 4 rather than by 2 (map bit 0).
- `bbc_access_req`  input  1  the current CPU cycle targets BBC space. Valid during the last `bbc_ck8` of phi1.
- `cpu_ck_phi2`  output  1  registered CPU phi2.
- `cpu_ck_phi1`  output  1  registered CPU phi1; always the complement of `cpu_ck_phi2`.
- `bbc_cycle`  output  1  registered; high exactly while the current phi2 is BBC-aligned.
- `locked`  output  1  phi0 phase tracker is locked.
- `sync_fault`  output  1  sticky; cleared only by `reset`.

## Operation
- **phi0 sampling**
  - `phi0_s` registers `bbc_ck2_phi0`; `phi0_d` registers `phi0_s`.
  - `armed` sets the first cycle `phi0_s` is 0 after reset.
  - rise = `armed & phi0_s & !phi0_d`.
- **Phase tracker**
  - 2-bit `ph` increments every cycle and is loaded with 1 in the cycle after a rise.
  - `locked` sets on a rise with `ph`==0, i.e. exactly 4 cycles after the previous rise.
  - `locked` clears on a rise with `ph`!=0, or on `ph`==0 with no rise.
  - When locked, `ph`==3 means `phi0_s` rises next cycle.
- **Fault counter**
  - Saturating counter increments while `!locked` and clears while locked.
  - Reaching `FAULT_LIMIT` sets `sync_fault`.
- **Mode register**
  - Captures {`hsclk_en`, `div_en`, `div4not2`} only on transitions into a PH1 state; never mid-phase.
  - Phase length N in `bbc_ck8` cycles:
    - hs=0: slow mode.
    - hs=1, div_en=0: N=1.
    - hs=1, div_en=1, div4not2=0: N=2.
    - hs=1, div_en=1, div4not2=1: N=4.
  - `div4not2` is ignored when `div_en`=0.
- **FSM states:** FAST_PH1, FAST_PH2, SYNC_PH1, SYNC_PH2.
  - Outputs are registered from the next state:
    - `cpu_ck_phi2` = next state is a PH2 state.
    - `bbc_cycle` = next state is SYNC_PH2.
  - 2-bit phase-length counter `cnt` resets to 0 on every state change.
  - FAST_PH1: at `cnt`==N-1, go to SYNC_PH1 if `bbc_access_req`, else go to FAST_PH2.
  - FAST_PH2: at `cnt`==N-1, go to FAST_PH1 if captured hs=1, else go to SYNC_PH1.
  - SYNC_PH1: go to SYNC_PH2 when `locked & ph==3`; otherwise hold with phi1 high indefinitely.
  - SYNC_PH2: lasts exactly 2 cycles, then goes to FAST_PH1 if newly captured hs=1, else to SYNC_PH1.
  - Slow mode is continuous SYNC_PH1/SYNC_PH2 alternation: `cpu_ck_phi2` equals `phi0_s`, one `bbc_ck8` behind the pin.
- **Phase widths**
  - Every phase lasts at least 1 `bbc_ck8`, so no runt pulse can occur.
  - Every SYNC_PH2 is exactly 2 cycles.

## Timing
- **Reset values:**
  - outputs: `cpu_ck_phi2`=0, `cpu_ck_phi1`=1, `bbc_cycle`=0, `locked`=0, `sync_fault`=0.
  - internal: state=SYNC_PH1, mode=slow, `ph`=0, `cnt`=0, `armed`=0, `phi0_s`=0, `phi0_d`=0.
- **First BBC-aligned phi2:** no earlier than the second observed rise after `armed` sets, since `locked` needs two rises 4 cycles apart.
- **Stretch latency:** a stretched access waits 0-3 extra `bbc_ck8` cycles in SYNC_PH1 beyond the FAST_PH1 length.
- **Simultaneous events:**
  - `bbc_access_req` is sampled only in the last FAST_PH1 cycle; it is ignored elsewhere, including in SYNC_PH1.
  - A mode input change takes effect at the next PH1 entry.
  - Loss of lock during SYNC_PH2 does not truncate the phase.
- **Reset mid-phase:** outputs go to their reset values immediately (asynchronous); `cpu_ck_phi2` may be cut short.

## Test plan
- **Reset and slow lock:** reset, then toggle phi0 (2 high / 2 low) → `locked`=1 after the 2nd rise; `cpu_ck_phi2` = phi0 delayed 1 cycle; `bbc_cycle`=1 on every phi2.
- **Fast N=1, no requests:** hs=1, div_en=0, `bbc_access_req`=0 → `cpu_ck_phi2` alternates 1 cycle high / 1 cycle low; `bbc_cycle`=0.
- **Fast N=2 with a request:** hs=1, div_en=1, `bbc_access_req`=1 once → phi1 is stretched until phi0 rises; phi2 is high for exactly 2 cycles coincident with `phi0_s`; `bbc_cycle`=1 for those 2 cycles; then back to 2/2 cycles.
- **Mode change mid-phase:** change div4not2 0→1 during FAST_PH2 → the current phase completes at N=2; the next phases are 4 cycles each.
- **phi0 stuck:** hold phi0 low in slow mode → `locked` drops after 4 cycles; `sync_fault`=1 after 32 unlocked cycles; phi1 is held high; restoring phi0 relocks, while `sync_fault` stays 1 until `reset`.
- **Reset pulse during phi2:** assert `reset` while `cpu_ck_phi2`=1 → `cpu_ck_phi2`=0 and `cpu_ck_phi1`=1 within the same cycle.
